// File: rtl/alu_wb_if.sv
// Handshake bundle between the ALU stage and the writeback buffer. The master
// drives in_* and out_ready; the slave (the buffer) drives in_ready and out_*.
interface alu_wb_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_zero;
  logic             in_carry;
  logic             in_negative;
  logic             in_overflow;
  logic [3:0]       in_flag_we;
  logic [4:0]       in_rd;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [4:0]       out_rd;
  logic             out_we;

  modport master (
    output in_valid, in_result, in_zero, in_carry, in_negative, in_overflow,
           in_flag_we, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_result, in_zero, in_carry, in_negative, in_overflow,
           in_flag_we, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_rd, out_we
  );
endinterface

// File: rtl/alu_wb_stage.sv
// Two-entry skid buffer behind the ALU: holds {result, flags, rd} beats, keeps
// the architectural flag register and counts retired (popped) operations.
module alu_wb_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_wb_if.slave          bus,
  output logic [3:0]       psw,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       dbg_count
);

  // Handshake: a beat moves on a rising edge where valid && ready are both 1.
  // in_ready is a function of registered state only, so out_ready never reaches it.
  logic [WIDTH-1:0] mem_result [2];
  logic [3:0]       mem_flags  [2];
  logic [4:0]       mem_rd     [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;
  logic             rdy_q;
  logic             push;
  logic             pop;
  logic [3:0]       in_flags;

  assign in_flags     = {bus.in_overflow, bus.in_negative, bus.in_carry, bus.in_zero};
  assign bus.in_ready = rdy_q && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  assign bus.out_result = mem_result[rptr];
  assign bus.out_flags  = mem_flags[rptr];
  assign bus.out_rd     = mem_rd[rptr];
  assign bus.out_we     = bus.out_valid && (mem_rd[rptr] != 5'd0);
  assign dbg_count      = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= '0;
        mem_flags[i]  <= '0;
        mem_rd[i]     <= '0;
      end
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count   <= 2'd0;
      rdy_q   <= 1'b0;
      psw     <= 4'b0000;
      retired <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (push) begin
        mem_result[wptr] <= bus.in_result;
        mem_flags[wptr]  <= in_flags;
        mem_rd[wptr]     <= bus.in_rd;
        wptr             <= ~wptr;
        // psw tracks accepted beats, so it may run ahead of the head entry.
        for (int i = 0; i < 4; i++) begin
          if (bus.in_flag_we[i]) psw[i] <= in_flags[i];
        end
      end
      if (pop) begin
        rptr    <= ~rptr;
        retired <= retired + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: a negedge monitor checks every cycle against a queue
// model; directed sections and a vector table drive the stimulus.
module tb_alu_wb_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n = 1'b0;
  logic [3:0]       psw;
  logic [CNT_W-1:0] retired;
  logic [1:0]       dbg_count;

  alu_wb_if #(.WIDTH(WIDTH)) bus ();

  alu_wb_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .psw       (psw),
    .retired   (retired),
    .dbg_count (dbg_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard model: entry = {result, flags, rd}
  logic [WIDTH+8:0] exp_q[$];
  logic [3:0]       m_psw = 4'b0000;
  logic [CNT_W-1:0] m_ret = '0;
  logic             m_rdy = 1'b0;
  logic             do_push = 1'b0;
  logic             do_pop = 1'b0;
  logic [WIDTH+8:0] in_beat;

  assign in_beat = {bus.in_result,
                    bus.in_overflow, bus.in_negative, bus.in_carry, bus.in_zero,
                    bus.in_rd};

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_psw   = 4'b0000;
      m_ret   = '0;
      m_rdy   = 1'b0;
      do_push = 1'b0;
      do_pop  = 1'b0;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_result", 64'(bus.out_result), 64'd0);
      chk("rst_out_we", 64'(bus.out_we), 64'd0);
      chk("rst_psw", 64'(psw), 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_rdy && exp_q.size() != 2));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("count", 64'(dbg_count), 64'(exp_q.size()));
      chk("psw", 64'(psw), 64'(m_psw));
      chk("retired", 64'(retired), 64'(m_ret));
      if (exp_q.size() != 0) begin
        chk("out_result", 64'(bus.out_result), 64'(exp_q[0][WIDTH+8:9]));
        chk("out_flags", 64'(bus.out_flags), 64'(exp_q[0][8:5]));
        chk("out_rd", 64'(bus.out_rd), 64'(exp_q[0][4:0]));
        chk("out_we", 64'(bus.out_we), 64'(exp_q[0][4:0] != 5'd0));
      end
      do_push = bus.in_valid && m_rdy && (exp_q.size() != 2);
      do_pop  = (exp_q.size() != 0) && bus.out_ready;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        m_ret = m_ret + 1'b1;
      end
      if (do_push) begin
        exp_q.push_back(in_beat);
        for (int i = 0; i < 4; i++)
          if (bus.in_flag_we[i]) m_psw[i] = in_beat[5+i];
      end
      m_rdy = 1'b1;
    end else begin
      m_rdy = 1'b0;
    end
    do_push = 1'b0;
    do_pop  = 1'b0;
  end

  // driver tasks
  task automatic set_beat(input logic [31:0] r, input logic [3:0] f,
                          input logic [3:0] we, input logic [4:0] rd);
    bus.in_result   = r;
    bus.in_overflow = f[3];
    bus.in_negative = f[2];
    bus.in_carry    = f[1];
    bus.in_zero     = f[0];
    bus.in_flag_we  = we;
    bus.in_rd       = rd;
  endtask

  task automatic drive_beat(input logic [31:0] r, input logic [3:0] f,
                            input logic [3:0] we, input logic [4:0] rd);
    bit took = 1'b0;
    set_beat(r, f, we, rd);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge clk);
      took = m_rdy && (exp_q.size() != 2);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!took) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  we;
    logic [4:0]  rd;
    logic [3:0]  exp_psw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_beat(32'd0, 4'd0, 4'd0, 5'd0);

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      set_beat($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               5'($urandom_range(0, 31)));
    end
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_psw", 64'(psw), 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    chk("reset_out_result", 64'(bus.out_result), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    cycles(1);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);

    // single beat
    drive_beat(32'h0000_0060, 4'b0000, 4'b1111, 5'd3);
    chk("single_out_result", 64'(bus.out_result), 64'h60);
    chk("single_out_we", 64'(bus.out_we), 64'd1);
    chk("single_psw", 64'(psw), 64'd0);
    cycles(1);
    chk("single_retired", 64'(retired), 64'd1);

    // back-pressure fill
    bus.out_ready = 1'b0;
    drive_beat(32'hFFFF_FFE0, 4'b0100, 4'b1111, 5'd5);
    drive_beat(32'h0000_0000, 4'b0011, 4'b1111, 5'd6);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_psw", 64'(psw), 64'b0011);
    set_beat(32'h1234_5678, 4'b1000, 4'b1111, 5'd7);
    bus.in_valid = 1'b1;
    cycles(3);
    chk("full_no_third", 64'(dbg_count), 64'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("drain_first", 64'(bus.out_result), 64'hFFFF_FFE0);
    cycles(1);
    chk("drain_ready_back", 64'(bus.in_ready), 64'd1);
    chk("drain_second", 64'(bus.out_result), 64'h0);
    cycles(1);
    chk("drain_retired", 64'(retired), 64'd3);

    // simultaneous push/pop streaming
    for (int i = 0; i < 8; i++) begin
      set_beat(32'h100 + 32'(i), 4'(i), 4'b0000, 5'(i + 1));
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (i > 0) chk("stream_count", 64'(dbg_count), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    cycles(1);
    chk("stream_retired", 64'(retired), 64'd11);
    chk("stream_empty", 64'(bus.out_valid), 64'd0);

    // flag masking table
    do_reset();
    vecs[0] = '{32'h8000_0000, 4'b1100, 4'b0100, 5'd1, 4'b0100};
    vecs[1] = '{32'h0000_0000, 4'b0001, 4'b0000, 5'd2, 4'b0100};
    vecs[2] = '{32'h0000_0001, 4'b0010, 4'b1111, 5'd3, 4'b0010};
    vecs[3] = '{32'h7FFF_FFFF, 4'b1000, 4'b1010, 5'd4, 4'b1000};
    vecs[4] = '{32'h0000_0000, 4'b0001, 4'b0001, 5'd0, 4'b1001};
    vecs[5] = '{32'hFFFF_FFFF, 4'b0110, 4'b0110, 5'd9, 4'b1111};
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive_beat(vecs[i].res, vecs[i].flg, vecs[i].we, vecs[i].rd);
      chk($sformatf("vec%0d_psw", i), 64'(psw), 64'(vecs[i].exp_psw));
      chk($sformatf("vec%0d_result", i), 64'(bus.out_result), 64'(vecs[i].res));
    end
    cycles(1);

    // r0 suppression
    bus.out_ready = 1'b0;
    drive_beat(32'hDEAD_BEEF, 4'b0000, 4'b0000, 5'd0);
    chk("r0_out_valid", 64'(bus.out_valid), 64'd1);
    chk("r0_out_we", 64'(bus.out_we), 64'd0);
    bus.out_ready = 1'b1;
    cycles(1);

    // retired wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 70000; cyc++) begin
      if (m_ret == 16'hFFFF && exp_q.size() == 0) break;
      if (32'(m_ret) + 32'(exp_q.size()) >= 32'hFFFF) begin
        bus.in_valid = 1'b0;
      end else begin
        set_beat(32'(cyc), 4'(cyc), 4'b0000, 5'(cyc));
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("wrap_preload", 64'(retired), 64'hFFFF);
    drive_beat(32'hCAFE_0001, 4'b0000, 4'b0000, 5'd1);
    cycles(1);
    chk("wrap_zero", 64'(retired), 64'd0);

    // reset mid-stream with two beats held
    bus.out_ready = 1'b0;
    drive_beat(32'hAAAA_0001, 4'b0001, 4'b1111, 5'd10);
    drive_beat(32'hAAAA_0002, 4'b0010, 4'b1111, 5'd11);
    chk("mid_full", 64'(dbg_count), 64'd2);
    rst_n = 1'b0;
    #2;
    chk("mid_async_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_async_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_async_result", 64'(bus.out_result), 64'd0);
    chk("mid_async_psw", 64'(psw), 64'd0);
    cycles(1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cycles(3);
    chk("mid_no_stale", 64'(bus.out_valid), 64'd0);
    chk("mid_count", 64'(dbg_count), 64'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycles(1);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
